// File: rtl/led_column_scanner.sv
// rtl/led_column_scanner.sv - double-buffered 8x8 LED column scanner with blanking and frame-aligned swap
module led_column_scanner #(
  parameter int DWELL = 50000,
  parameter int BLANK = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR_EN,
  input  logic [2:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic       SWAP_REQ,
  output logic       SWAP_ACK,
  output logic       FRAME_DONE,
  output logic [2:0] SELECT,
  output logic [7:0] D
);

  typedef enum logic {
    ST_BLANKING = 1'b0,
    ST_SHOWING  = 1'b1
  } state_t;

  localparam logic [19:0] DWELL_LAST = 20'(DWELL - 1);
  localparam logic [19:0] BLANK_LAST = 20'(BLANK - 1);
  // With no blanking the reset state behaves as the first showing cycle of column 0
  localparam bit NO_BLANK = (BLANK == 0);

  state_t      r_state;
  state_t      w_state_next;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_next;
  logic [2:0]  r_sel;
  logic [2:0]  w_sel_next;
  logic [7:0]  r_d;
  logic [7:0]  w_d_next;
  logic        r_ack;
  logic        r_fd;
  logic        w_fd_next;

  logic [7:0]  r_buf_a [8];
  logic [7:0]  r_buf_b [8];
  logic        r_front_b;

  logic        w_showing;
  logic        w_col_end;
  logic        w_swap;
  logic        w_next_front_b;
  logic [7:0]  w_next_row;

  // Next-state, counter and output data; the row shown next comes from the post-swap front,
  // with a same-cycle write forwarded because it lands in the buffer that becomes front.
  always_comb begin
    w_showing      = (r_state == ST_SHOWING) || NO_BLANK;
    w_col_end      = w_showing && (r_cnt == DWELL_LAST);
    w_swap         = w_col_end && (r_sel == 3'd7) && SWAP_REQ;
    w_next_front_b = r_front_b ^ w_swap;
    w_fd_next      = w_col_end && (r_sel == 3'd7);

    w_state_next = r_state;
    w_cnt_next   = r_cnt + 20'd1;
    w_sel_next   = r_sel;

    if (w_showing) begin
      if (w_col_end) begin
        w_cnt_next   = 20'd0;
        w_sel_next   = r_sel + 3'd1;
        w_state_next = NO_BLANK ? ST_SHOWING : ST_BLANKING;
      end else begin
        w_state_next = ST_SHOWING;
      end
    end else if (r_cnt == BLANK_LAST) begin
      w_cnt_next   = 20'd0;
      w_state_next = ST_SHOWING;
    end

    w_next_row = w_next_front_b ? r_buf_b[w_sel_next] : r_buf_a[w_sel_next];
    if (w_swap && WR_EN && (WR_ADDR == w_sel_next)) begin
      w_next_row = WR_DATA;
    end

    w_d_next = (w_state_next == ST_SHOWING) ? w_next_row : 8'h00;
  end

  // Scan state, column counter and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_BLANKING;
      r_cnt   <= 20'd0;
      r_sel   <= 3'd0;
      r_d     <= 8'h00;
      r_ack   <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sel   <= w_sel_next;
      r_d     <= w_d_next;
      r_ack   <= w_swap;
      r_fd    <= w_fd_next;
    end
  end

  // Frame buffers: writes always target the current back buffer, roles flip on swap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_front_b <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_buf_a[i] <= 8'h00;
        r_buf_b[i] <= 8'h00;
      end
    end else begin
      if (WR_EN) begin
        if (r_front_b) begin
          r_buf_a[WR_ADDR] <= WR_DATA;
        end else begin
          r_buf_b[WR_ADDR] <= WR_DATA;
        end
      end
      if (w_swap) begin
        r_front_b <= ~r_front_b;
      end
    end
  end

  assign SWAP_ACK   = r_ack;
  assign FRAME_DONE = r_fd;
  assign SELECT     = r_sel;
  assign D          = r_d;

endmodule

// File: tb/tb_led_column_scanner.sv
// tb/tb_led_column_scanner.sv - scoreboard bench for led_column_scanner (DWELL=4/BLANK=2 and DWELL=1/BLANK=0)
module tb_led_column_scanner;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [2:0] WR_ADDR = 3'd0;
  logic [7:0] WR_DATA = 8'h00;
  logic       SWAP_REQ = 1'b0;

  logic       ack0, fd0, ack1, fd1;
  logic [2:0] sel0, sel1;
  logic [7:0] d0, d1;

  led_column_scanner #(.DWELL(4), .BLANK(2)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .SWAP_REQ(SWAP_REQ), .SWAP_ACK(ack0), .FRAME_DONE(fd0), .SELECT(sel0), .D(d0)
  );

  led_column_scanner #(.DWELL(1), .BLANK(0)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .SWAP_REQ(SWAP_REQ), .SWAP_ACK(ack1), .FRAME_DONE(fd1), .SELECT(sel1), .D(d1)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] d;
    logic       ack;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  int cp[2] = '{6, 1};
  int cb[2] = '{2, 0};
  logic [7:0] mbuf [2][2][8];
  int mfront[2];
  int m_cyc;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, m_cyc);
    end
  endtask

  function automatic exp_t expect_at(input int k, input int cyc, input logic swp);
    exp_t e;
    int per;
    int p;
    per   = 8 * cp[k];
    p     = cyc % per;
    e.sel = 3'(p / cp[k]);
    e.d   = ((p % cp[k]) < cb[k]) ? 8'h00 : mbuf[k][mfront[k]][p / cp[k]];
    e.ack = swp;
    e.fd  = (p == 0) && (cyc != 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mfront[k] = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++) mbuf[k][b][i] = 8'h00;
    end
    m_cyc = 0;
  endtask

  task automatic check_cycle();
    exp_t e;
    e = q.pop_front();
    chk("sel0", 8'(sel0), 8'(e.sel));
    chk("d0", d0, e.d);
    chk("ack0", 8'(ack0), 8'(e.ack));
    chk("fd0", 8'(fd0), 8'(e.fd));
    e = q.pop_front();
    chk("sel1", 8'(sel1), 8'(e.sel));
    chk("d1", d1, e.d);
    chk("ack1", 8'(ack1), 8'(e.ack));
    chk("fd1", 8'(fd1), 8'(e.fd));
  endtask

  task automatic tick();
    int p;
    logic swp;
    for (int k = 0; k < 2; k++) begin
      p = m_cyc % (8 * cp[k]);
      if (WR_EN) mbuf[k][1 - mfront[k]][WR_ADDR] = WR_DATA;
      swp = (p == 8 * cp[k] - 1) && SWAP_REQ;
      if (swp) mfront[k] = 1 - mfront[k];
      q.push_back(expect_at(k, m_cyc + 1, swp));
    end
    m_cyc++;
    @(posedge CLK);
    #1;
    check_cycle();
  endtask

  task automatic check_reset();
    chk("rst_sel0", 8'(sel0), 8'h00);
    chk("rst_d0", d0, 8'h00);
    chk("rst_ack0", 8'(ack0), 8'h00);
    chk("rst_fd0", 8'(fd0), 8'h00);
    chk("rst_sel1", 8'(sel1), 8'h00);
    chk("rst_d1", d1, 8'h00);
    chk("rst_ack1", 8'(ack1), 8'h00);
    chk("rst_fd1", 8'(fd1), 8'h00);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    q.push_back(expect_at(0, 0, 1'b0));
    q.push_back(expect_at(1, 0, 1'b0));
    #1;
    check_cycle();
  endtask

  task automatic tick_until(input int per, input int pos);
    for (int i = 0; i < 200 && (m_cyc % per) != pos; i++) tick();
  endtask

  initial begin
    model_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset();
    release_reset();

    repeat (96) tick();

    for (int i = 0; i < 8; i++) begin
      WR_EN   = 1'b1;
      WR_ADDR = 3'(i);
      WR_DATA = 8'(1 << i);
      tick();
    end
    WR_EN = 1'b0;
    SWAP_REQ = 1'b1;
    tick_until(48, 0);
    SWAP_REQ = 1'b0;
    repeat (48) tick();

    WR_EN   = 1'b1;
    WR_ADDR = 3'd3;
    WR_DATA = 8'hFF;
    tick();
    WR_EN = 1'b0;
    tick_until(48, 0);
    repeat (48) tick();

    tick_until(48, 47);
    SWAP_REQ = 1'b1;
    WR_EN    = 1'b1;
    WR_ADDR  = 3'd5;
    WR_DATA  = 8'hAA;
    tick();
    WR_EN    = 1'b0;
    SWAP_REQ = 1'b0;
    repeat (48) tick();

    tick_until(48, 27);
    RST_N = 1'b0;
    #1;
    check_reset();
    @(posedge CLK);
    release_reset();
    SWAP_REQ = 1'b1;
    tick();
    tick_until(48, 0);
    SWAP_REQ = 1'b0;
    repeat (48) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
